rx_frame_ctrl: RTL and testbench

User-clock-domain receive controller that drains the SNI receive byte FIFO, delimits frames on the per-byte end-of-data flag, applies destination-address filtering and length checks, and presents accepted frames on a byte-wide valid/ready stream with last/error sideband. It sits between the RX FIFO read port and the MAC user logic, and keeps saturating good/drop frame counters.

---
 rtl/rx_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
//
// Drains the receive byte FIFO in the user clock domain and splits the byte
// stream into frames using the per-byte end-of-data flag. It filters frames on
// destination address and checks their length. Accepted frames are presented
// on a byte-wide valid/ready stream with last/error sideband. Saturating
// good/drop frame counters are kept.
//
// Ports
//   clk_i            user clock, rising edge
//   rst_i            synchronous active-high reset
//   enable_i         accept frames (sampled when a frame's first byte arrives)
//   promisc_i        accept any destination address
//   accept_mcast_i   accept destination addresses with the group bit set
//   fifo_empty_i     RX FIFO empty
//   fifo_dout_i      FIFO read data, valid one cycle after fifo_rden_o
//   fifo_eod_i       end-of-data flag travelling with fifo_dout_i
//   fifo_rden_o      FIFO read strobe
//   m_tdata_o        output byte
//   m_tvalid_o       output byte valid
//   m_tready_i       downstream accepts byte
//   m_tlast_o        last byte of frame
//   m_tuser_o        frame error, meaningful with m_tlast_o
//   frame_ok_cnt_o   frames delivered without error (saturating)
//   frame_drop_cnt_o frames dropped or delivered with error (saturating)
// -----------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int unsigned MIN_LEN  = 64,
    parameter int unsigned MAX_LEN  = 1518
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        promisc_i,
    input  logic        accept_mcast_i,
    input  logic        fifo_empty_i,
    input  logic [7:0]  fifo_dout_i,
    input  logic        fifo_eod_i,
    output logic        fifo_rden_o,
    output logic [7:0]  m_tdata_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        m_tlast_o,
    output logic        m_tuser_o,
    output logic [15:0] frame_ok_cnt_o,
    output logic [15:0] frame_drop_cnt_o
);

    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_HDR_OUT = 3'd2,
        S_FWD     = 3'd3,
        S_DROP    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        rd_pend_q;
    logic [10:0] len_q, len_d;
    logic [47:0] da_q, da_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic        promisc_q, promisc_d;
    logic        mcast_q, mcast_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        hs_s;
    logic        out_free_s;
    logic        rden_s;
    logic        drop_evt_s;
    logic        addr_ok_s;
    logic [10:0] len_inc_s;
    logic [47:0] da_full_s;
    logic [7:0]  hdr_byte_s;
    logic [1:0]  drop_inc_s;

    // Saturating add used by both frame counters.
    function automatic logic [15:0] sat_add16(input logic [15:0] val, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, val} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Shared helper terms: handshake, output-register availability, header view.
    always_comb begin
        hs_s       = tvalid_q & m_tready_i;
        out_free_s = ~tvalid_q | hs_s;
        len_inc_s  = (len_q == 11'h7FF) ? len_q : (len_q + 11'd1);
        // Destination address as it stands once the byte now arriving is shifted in.
        da_full_s  = {da_q[39:0], fifo_dout_i};
        // Filter modes are the ones captured at frame start, not the live inputs.
        addr_ok_s  = (da_full_s == MAC_ADDR) || (da_full_s == 48'hFFFF_FFFF_FFFF) ||
                     promisc_q || (mcast_q && da_full_s[40]);
        hdr_byte_s = da_q[(6'd40 - {hdr_idx_q, 3'b000}) +: 8];
    end

    // FIFO read strobe: one read in flight at most, and FWD reads only when the
    // output register is guaranteed free for the returning byte.
    always_comb begin
        rden_s = 1'b0;
        if (!rst_i && !fifo_empty_i && !rd_pend_q) begin
            case (state_q)
                S_IDLE, S_HDR, S_DROP: rden_s = 1'b1;
                S_FWD:                 rden_s = ~tvalid_q | (hs_s & ~tlast_q);
                default:               rden_s = 1'b0;
            endcase
        end else begin
            rden_s = 1'b0;
        end
    end

    // Frame FSM: next state, header capture, output register loads, drop events.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        da_d       = da_q;
        hdr_idx_d  = hdr_idx_q;
        promisc_d  = promisc_q;
        mcast_d    = mcast_q;
        trunc_d    = trunc_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        tvalid_d   = tvalid_q & ~hs_s;
        drop_evt_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_pend_q) begin
                    len_d     = 11'd1;
                    da_d      = {40'd0, fifo_dout_i};
                    promisc_d = promisc_i;
                    mcast_d   = accept_mcast_i;
                    if (fifo_eod_i) begin
                        drop_evt_s = 1'b1;
                    end else if (enable_i) begin
                        state_d = S_HDR;
                    end else begin
                        state_d = S_DROP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (rd_pend_q) begin
                    len_d = len_inc_s;
                    da_d  = da_full_s;
                    if (fifo_eod_i) begin
                        // Header runt, including eod on the sixth byte.
                        drop_evt_s = 1'b1;
                        state_d    = S_IDLE;
                    end else if (len_q == 11'd5) begin
                        if (addr_ok_s) begin
                            state_d = S_HDR_OUT;
                            // Load DA byte 0 straight away when possible to keep
                            // the two-cycle read-to-valid latency.
                            if (out_free_s) begin
                                tvalid_d  = 1'b1;
                                tdata_d   = da_full_s[47:40];
                                tlast_d   = 1'b0;
                                tuser_d   = 1'b0;
                                hdr_idx_d = 3'd1;
                            end else begin
                                hdr_idx_d = 3'd0;
                            end
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        state_d = S_HDR;
                    end
                end else begin
                    state_d = S_HDR;
                end
            end
            S_HDR_OUT: begin
                if (out_free_s) begin
                    tvalid_d = 1'b1;
                    tdata_d  = hdr_byte_s;
                    tlast_d  = 1'b0;
                    tuser_d  = 1'b0;
                    if (hdr_idx_q == 3'd5) begin
                        state_d = S_FWD;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_HDR_OUT;
                end
            end
            S_FWD: begin
                if (rd_pend_q) begin
                    len_d    = len_inc_s;
                    tvalid_d = 1'b1;
                    tdata_d  = fifo_dout_i;
                    if (fifo_eod_i) begin
                        tlast_d = 1'b1;
                        tuser_d = (len_inc_s < MIN_LEN_L);
                    end else if (len_inc_s == MAX_LEN_L) begin
                        // Oversize: close the frame with error and discard the rest.
                        tlast_d = 1'b1;
                        tuser_d = 1'b1;
                        trunc_d = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        tlast_d = 1'b0;
                        tuser_d = 1'b0;
                    end
                end else if (hs_s && tlast_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FWD;
                end
            end
            S_DROP: begin
                if (rd_pend_q && fifo_eod_i) begin
                    // A truncated frame was already counted at its last-byte handshake.
                    drop_evt_s = ~trunc_q;
                    trunc_d    = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame counters; a drop event and an errored handshake may coincide.
    always_comb begin
        drop_inc_s = {1'b0, hs_s & tlast_q & tuser_q} + {1'b0, drop_evt_s};
        ok_cnt_d   = sat_add16(ok_cnt_q, {1'b0, hs_s & tlast_q & ~tuser_q});
        drop_cnt_d = sat_add16(drop_cnt_q, drop_inc_s);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rd_pend_q  <= 1'b0;
            len_q      <= 11'd0;
            da_q       <= 48'd0;
            hdr_idx_q  <= 3'd0;
            promisc_q  <= 1'b0;
            mcast_q    <= 1'b0;
            trunc_q    <= 1'b0;
            tdata_q    <= 8'd0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            ok_cnt_q   <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rden_s;
            len_q      <= len_d;
            da_q       <= da_d;
            hdr_idx_q  <= hdr_idx_d;
            promisc_q  <= promisc_d;
            mcast_q    <= mcast_d;
            trunc_q    <= trunc_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fifo_rden_o      = rden_s;
    assign m_tdata_o        = tdata_q;
    assign m_tvalid_o       = tvalid_q;
    assign m_tlast_o        = tlast_q;
    assign m_tuser_o        = tuser_q;
    assign frame_ok_cnt_o   = ok_cnt_q;
    assign frame_drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: a FIFO model feeds frames, expected output bytes are
// queued when each frame is queued, and compared on every output handshake.
module tb_rx_frame_ctrl;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam int MIN_L = 64;
    localparam int MAX_L = 1518;

    logic        clk = 1'b0;
    logic        rst, enable, promisc, accept_mcast;
    logic        fifo_empty, fifo_eod, fifo_rden;
    logic [7:0]  fifo_dout, m_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic [15:0] ok_cnt, drop_cnt;

    always #5 clk = ~clk;

    rx_frame_ctrl #(.MAC_ADDR(MAC), .MIN_LEN(MIN_L), .MAX_LEN(MAX_L)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .promisc_i        (promisc),
        .accept_mcast_i   (accept_mcast),
        .fifo_empty_i     (fifo_empty),
        .fifo_dout_i      (fifo_dout),
        .fifo_eod_i       (fifo_eod),
        .fifo_rden_o      (fifo_rden),
        .m_tdata_o        (m_tdata),
        .m_tvalid_o       (m_tvalid),
        .m_tready_i       (m_tready),
        .m_tlast_o        (m_tlast),
        .m_tuser_o        (m_tuser),
        .frame_ok_cnt_o   (ok_cnt),
        .frame_drop_cnt_o (drop_cnt)
    );

    logic [8:0] fifo_q[$];   // {eod, byte}
    logic [9:0] exp_q[$];    // {tuser, tlast, byte}
    int total = 0;
    int bad = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    logic       rd_q;
    logic [8:0] rd_ent;
    logic       rdy_rand, gap_rand, stalled;
    logic [9:0] held;

    // One clock: drive inputs at negedge, then check the handshake due at the next posedge.
    task automatic cycle();
        logic [9:0] e;
        @(negedge clk);
        if (rd_q) begin
            fifo_dout = rd_ent[7:0];
            fifo_eod  = rd_ent[8];
        end else begin
            fifo_dout = 8'($urandom);
            fifo_eod  = 1'($urandom);
        end
        if (stalled) begin
            total++;
            assert (m_tvalid === 1'b1 && {m_tuser, m_tlast, m_tdata} === held)
            else begin
                bad++;
                $error("FAIL stall_hold got v=%b %h exp v=1 %h", m_tvalid, {m_tuser, m_tlast, m_tdata}, held);
            end
        end
        m_tready   = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        fifo_empty = (fifo_q.size() == 0) || (gap_rand && ($urandom_range(0, 3) == 0));
        #1;
        if (m_tvalid && m_tready) begin
            total++;
            assert (exp_q.size() != 0)
            else begin
                bad++;
                $error("FAIL unexpected_byte got=%h exp=none", m_tdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert (m_tdata === e[7:0] && m_tlast === e[8] && (!e[8] || m_tuser === e[9]))
                else begin
                    bad++;
                    $error("FAIL out_byte got data=%h last=%b user=%b exp data=%h last=%b user=%b",
                           m_tdata, m_tlast, m_tuser, e[7:0], e[8], e[9]);
                end
            end
        end
        stalled = m_tvalid && !m_tready;
        held    = {m_tuser, m_tlast, m_tdata};
        if (fifo_rden) begin
            total++;
            assert (!fifo_empty && fifo_q.size() != 0)
            else begin
                bad++;
                $error("FAIL read_when_empty got rden=1 exp rden=0");
            end
            rd_q   = 1'b1;
            rd_ent = (fifo_q.size() != 0) ? fifo_q.pop_front() : 9'h000;
        end else begin
            rd_q = 1'b0;
        end
    endtask

    // Queue a frame into the FIFO model and record what should come out.
    task automatic send_frame(input int len, input logic [47:0] da, input logic [7:0] seed);
        logic [7:0] bytes[$];
        logic       acc, lst, usr;
        int         out_n;
        for (int i = 0; i < len; i++) begin
            if (i < 6) bytes.push_back(da[47 - 8*i -: 8]);
            else       bytes.push_back(8'(int'(seed) + i));
            fifo_q.push_back({(i == len - 1), bytes[i]});
        end
        acc = (da == MAC) || (da == BCAST) || promisc || (accept_mcast && da[40]);
        if (!enable || len <= 6 || !acc) begin
            exp_drop++;
        end else begin
            out_n = (len > MAX_L) ? MAX_L : len;
            for (int i = 0; i < out_n; i++) begin
                lst = (i == out_n - 1);
                usr = lst && (len > MAX_L || len < MIN_L);
                exp_q.push_back({usr, lst, bytes[i]});
            end
            if (len > MAX_L || len < MIN_L) exp_drop++;
            else                            exp_ok++;
        end
    endtask

    // Run until everything queued has been consumed and delivered, bounded.
    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (!(fifo_q.size() == 0 && !rd_q && exp_q.size() == 0 && !m_tvalid) && n < budget) begin
            cycle();
            n++;
        end
        total++;
        assert (n < budget)
        else begin
            bad++;
            $error("FAIL %s_timeout got fifo_left=%0d exp_left=%0d exp 0/0", tag, fifo_q.size(), exp_q.size());
        end
        cycle();
        cycle();
    endtask

    task automatic check_cnt(input string tag);
        total++;
        assert (ok_cnt === 16'(exp_ok))
        else begin
            bad++;
            $error("FAIL %s_ok_cnt got=%0d exp=%0d", tag, ok_cnt, exp_ok);
        end
        total++;
        assert (drop_cnt === 16'(exp_drop))
        else begin
            bad++;
            $error("FAIL %s_drop_cnt got=%0d exp=%0d", tag, drop_cnt, exp_drop);
        end
    endtask

    // Reset with the FIFO model cleared, then check the cleared outputs a cycle later.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst        = 1'b1;
        fifo_empty = 1'b1;
        m_tready   = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        rd_q     = 1'b0;
        stalled  = 1'b0;
        exp_ok   = 0;
        exp_drop = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        assert ({fifo_rden, m_tvalid, m_tlast, m_tuser} === 4'b0000 && m_tdata === 8'h00)
        else begin
            bad++;
            $error("FAIL %s_outputs got rden=%b v=%b l=%b u=%b d=%h exp all 0",
                   tag, fifo_rden, m_tvalid, m_tlast, m_tuser, m_tdata);
        end
        check_cnt(tag);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; promisc = 1'b0; accept_mcast = 1'b0;
        fifo_empty = 1'b1; fifo_dout = 8'h00; fifo_eod = 1'b0; m_tready = 1'b0;
        rd_q = 1'b0; rd_ent = 9'h000; stalled = 1'b0; held = 10'h000;
        rdy_rand = 1'b0; gap_rand = 1'b0;
        do_reset("reset");

        // Unicast minimum-size frame.
        send_frame(64, MAC, 8'h10);
        drain(2000, "unicast64");
        check_cnt("unicast64");

        // Foreign DA, then the same with promiscuous mode.
        send_frame(64, 48'h02_00_00_00_00_99, 8'h20);
        drain(2000, "filtered");
        check_cnt("filtered");
        promisc = 1'b1;
        send_frame(64, 48'h02_00_00_00_00_99, 8'h30);
        drain(2000, "promisc");
        check_cnt("promisc");
        promisc = 1'b0;

        // Short frames: delivered undersize, header runts, one byte under minimum.
        send_frame(40, BCAST, 8'h40);
        drain(2000, "bcast40");
        check_cnt("bcast40");
        send_frame(4, MAC, 8'h50);
        send_frame(6, MAC, 8'h58);
        drain(2000, "runts");
        check_cnt("runts");
        send_frame(63, MAC, 8'h60);
        drain(2000, "len63");
        check_cnt("len63");

        // Oversize truncation, next frame intact, exact maximum length.
        send_frame(1600, MAC, 8'h70);
        send_frame(64, MAC, 8'h80);
        drain(8000, "trunc");
        check_cnt("trunc");
        send_frame(MAX_L, MAC, 8'h90);
        drain(8000, "maxlen");
        check_cnt("maxlen");

        // Back-to-back frames with random backpressure and FIFO gaps.
        rdy_rand = 1'b1;
        gap_rand = 1'b1;
        accept_mcast = 1'b1;
        send_frame(100, MAC, 8'hA0);
        send_frame(70, 48'h01_00_5E_00_00_01, 8'hB0);
        send_frame(65, BCAST, 8'hC0);
        drain(8000, "random3");
        check_cnt("random3");
        accept_mcast = 1'b0;
        send_frame(70, 48'h01_00_5E_00_00_02, 8'hC8);
        send_frame(80, MAC, 8'hD0);
        drain(8000, "mcast_off");
        check_cnt("mcast_off");
        rdy_rand = 1'b0;
        gap_rand = 1'b0;

        // Fresh counters, disabled frame, enabled frame, reset mid-frame.
        do_reset("reset2");
        enable = 1'b0;
        send_frame(64, MAC, 8'hE0);
        drain(2000, "disabled");
        check_cnt("disabled");
        enable = 1'b1;
        send_frame(64, MAC, 8'hE8);
        drain(2000, "enabled");
        check_cnt("enabled");
        send_frame(100, MAC, 8'hF0);
        for (int i = 0; i < 40; i++) cycle();
        do_reset("midframe_rst");
        send_frame(64, MAC, 8'hF8);
        drain(2000, "after_rst");
        check_cnt("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
